// File: rtl/booth_controller_if.sv
// Handshake and datapath-control bundle for booth_controller.
// master = controller side, slave = system/datapath side.
interface booth_controller_if #(
    parameter int NB = 4
);
    localparam int SW = $clog2(NB) + 1;

    logic          start;
    logic          ready;
    logic          busy;
    logic          done;
    logic [NB-1:0] q_obs;
    logic          load;
    logic          arithmetic;
    logic          shift;
    logic [SW-1:0] shmnt;

    modport master (
        input  start, q_obs,
        output ready, busy, done, load, arithmetic, shift, shmnt
    );

    modport slave (
        output start, q_obs,
        input  ready, busy, done, load, arithmetic, shift, shmnt
    );
endinterface

// File: rtl/booth_controller.sv
// Radix-2 Booth multiplier control FSM with a shadow copy of the Booth LSB.
// Define BOOTH_SKIP_EN to shift across runs of equal multiplier bits in one step.
module booth_controller #(
    parameter int NB = 4
) (
    input  logic               clk,
    input  logic               rst,
    booth_controller_if.master bus
);
    localparam int CW = $clog2(NB) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_ARITH,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_lsb;
    logic [CW-1:0] w_k;
    logic [NB-1:0] w_q_sh;
    logic          w_new_lsb;

`ifdef BOOTH_SKIP_EN
    logic [CW-1:0] w_run;
    logic          w_stop;

    // Run length of equal bits starting at Q[0], never past the bits still owed.
    always_comb begin
        w_run  = CW'(1);
        w_stop = 1'b0;
        for (int i = 1; i < NB; i++) begin
            if (!w_stop && (bus.q_obs[i] == bus.q_obs[i-1])) begin
                w_run = w_run + CW'(1);
            end else begin
                w_stop = 1'b1;
            end
        end
        w_k = (w_run > r_cnt) ? r_cnt : w_run;
    end
`else
    assign w_k = CW'(1);
`endif

    // The bit that lands in the Booth LSB after an arithmetic shift by k is Q[k-1].
    assign w_q_sh    = bus.q_obs >> (w_k - CW'(1));
    assign w_new_lsb = w_q_sh[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lsb   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_state <= w_next;
            case (r_state)
                S_LOAD: begin
                    r_cnt <= CW'(NB);
                    r_lsb <= 1'b0;
                end
                S_SHIFT: begin
                    r_cnt <= r_cnt - w_k;
                    r_lsb <= w_new_lsb;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_next         = r_state;
        bus.ready      = 1'b0;
        bus.busy       = 1'b1;
        bus.done       = 1'b0;
        bus.load       = 1'b0;
        bus.arithmetic = 1'b0;
        bus.shift      = 1'b0;
        bus.shmnt      = '0;
        case (r_state)
            S_IDLE: begin
                bus.ready = 1'b1;
                bus.busy  = 1'b0;
                if (bus.start) w_next = S_LOAD;
            end
            S_LOAD: begin
                bus.load = 1'b1;
                w_next   = S_EVAL;
            end
            S_EVAL: begin
                w_next = (bus.q_obs[0] ^ r_lsb) ? S_ARITH : S_SHIFT;
            end
            S_ARITH: begin
                bus.arithmetic = 1'b1;
                w_next         = S_SHIFT;
            end
            S_SHIFT: begin
                bus.shift = 1'b1;
                bus.shmnt = w_k;
                w_next    = (r_cnt == w_k) ? S_DONE : S_EVAL;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: doc/booth_controller.md
Name: booth_controller

Overview:
- Control FSM directly upstream of the radix-2 Booth multiplier datapath; drives its load, arithmetic, shift and shmnt controls.
- Watches the datapath's Q register and keeps a shadow copy of the Booth LSB, so every decision matches the datapath's {Q[0], LSB} pair.
- Provides a start/ready/done handshake to the system above.
- Optional run-skipping: shifts across runs of equal multiplier bits in a single multi-bit shift.

Parameters:
NB, 4, operand width; must equal the datapath nb; NB >= 2.

Ports:
clk  input  1  rising-edge clock, shared with datapath
rst  input  1  synchronous active-high reset
start  input  1  request a multiply; sampled only in IDLE
ready  output  1  high exactly while in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: product valid in datapath {A,Q}
q_obs  input  NB  datapath Q register, current value
load  output  1  datapath load strobe
arithmetic  output  1  datapath add/sub strobe
shift  output  1  datapath shift strobe
shmnt  output  $clog2(NB)+1  datapath arithmetic-shift amount, 0..NB

Behaviour:
- States: IDLE, LOAD, EVAL, ARITH, SHIFT, DONE.
- Control outputs are pure decodes of the current state. The datapath acts on the clk edge that ends that state.
- Reset:
  - state=IDLE, cnt=0, lsb=0.
  - load=arithmetic=shift=0, shmnt=0, done=0, ready=1, busy=0.
  - Reset mid-operation aborts cleanly: next cycle IDLE with all controls low. Datapath contents are then don't-care.
- IDLE: start=1 -> LOAD. Otherwise stay.
- LOAD:
  - load=1.
  - Internal cnt<=NB, lsb<=0.
  - -> EVAL.
- EVAL:
  - No strobes.
  - {q_obs[0],lsb}=10 or 01 -> ARITH; 00 or 11 -> SHIFT.
- ARITH: arithmetic=1 for exactly one cycle -> SHIFT. Q is unchanged, so q_obs stays valid.
- SHIFT:
  - shift=1, shmnt=k.
  - Updates: lsb<=q_obs[k-1], cnt<=cnt-k.
  - cnt-k==0 -> DONE; else -> EVAL.
  - Baseline k=1.
- DONE: done=1 for one cycle -> IDLE.
- start while busy, or in the DONE cycle: ignored, never queued.
- Per-bit cost (baseline): 2 cycles for 00/11 pairs, 3 cycles for 01/10 pairs.
- Total cycles, start-accept to done pulse inclusive: 1 (LOAD) + sum of per-bit costs + 1 (DONE).
- Invariants:
  - At most one of load/arithmetic/shift is high in any cycle.
  - shmnt=0 whenever shift=0.
  - cnt never underflows; k is always between 1 and cnt.

Optional Feature:
- Macro BOOTH_SKIP_EN.
- Defined:
  - In SHIFT, k = 1 + count of consecutive i>=1, starting at i=1, with q_obs[i]==q_obs[i-1].
  - Counting stops at the first mismatch; k is capped at cnt.
  - Guarantees the next EVAL pair is a transition, or the operation is complete.
  - Multiplier 0 or all-ones finishes with one EVAL and one SHIFT of NB.
- Undefined: k is always 1, giving exactly NB SHIFT states per multiply.
- The product is identical in both builds; only cycle count differs.

Test Plan:
- Bench instantiates booth_controller plus the datapath with NB=4; every check below uses that pair.
- M=3, Q=5, start one cycle:
  - done after 14 cycles (all four pairs are transitions).
  - {A,Q}=8'h0F.
  - Exactly 4 arithmetic and 4 shift strobes.
- M=4'b1101 (-3), Q=2: {A,Q}=8'hFA (-6).
  - Baseline: done after 12 cycles.
  - BOOTH_SKIP_EN: shmnt sequence 1,1,2 and done after 10 cycles.
- M=7, Q=0:
  - Baseline: 4 shifts with shmnt=1.
  - BOOTH_SKIP_EN: exactly one shift with shmnt=4.
  - In both builds, done gives {A,Q}=0 and arithmetic is never asserted.
- M=5, Q=4'b1111 (-1): {A,Q}=8'hFB (-5).
  - BOOTH_SKIP_EN: one arithmetic, then one shift with shmnt=4.
- Handshake:
  - start held high for 20 cycles: ready low while busy; only one load is issued for the first multiply; the second multiply starts from IDLE.
  - Pulse start during DONE: ignored, no load.
- rst asserted in cycle 3 of a multiply:
  - Next cycle IDLE, ready=1, all strobes 0, no done pulse.
  - A following start with M=2, Q=3 yields {A,Q}=8'h06.
